conv_engine: RTL and testbench

//  Compute-side responder to the convolution controller. Fetches one packed feature-map

---
 rtl/conv_engine_if.sv | 31 +++
 rtl/conv_engine.sv | 125 ++++++++++++
 tb/tb_conv_engine.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/conv_engine_if.sv
// conv_engine_if: controller <-> convolution engine handshake and operand bus
//   i_load          controller in load state (level)
//   i_compute_conv  controller compute request (level)
//   i_fm_word       packed feature-map word from BRAM0
//   i_k_word        packed kernel word from BRAM1
//   o_ready2compute operands captured, engine waiting for compute
//   o_conv_done     one-cycle pulse, o_result valid
//   o_result        signed saturated dot product for BRAM2 din
//   o_busy          engine in FETCH/MAC/DONE
interface conv_engine_if #(
    parameter int DATA_W      = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int OUT_W       = 16
);
    logic                          i_load;
    logic                          i_compute_conv;
    logic [DATA_W*KERNEL_SIZE-1:0] i_fm_word;
    logic [DATA_W*KERNEL_SIZE-1:0] i_k_word;
    logic                          o_ready2compute;
    logic                          o_conv_done;
    logic [OUT_W-1:0]              o_result;
    logic                          o_busy;
    modport master (
        output i_load, i_compute_conv, i_fm_word, i_k_word,
        input  o_ready2compute, o_conv_done, o_result, o_busy
    );
    modport slave (
        input  i_load, i_compute_conv, i_fm_word, i_k_word,
        output o_ready2compute, o_conv_done, o_result, o_busy
    );
endinterface

// File: rtl/conv_engine.sv
// conv_engine: sequential signed MAC responder to the convolution controller
//   i_clk  clock, all state on rising edge
//   i_rst  synchronous active-high reset
//   bus    conv_engine_if slave: load/compute requests and packed operands in,
//          ready/done/busy and saturated result out
// Build option: define CONV_RELU_EN to clamp negative results to zero (ReLU fused).
module conv_engine #(
    parameter int DATA_W      = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int OUT_W       = 16,
    parameter int RD_LAT      = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    conv_engine_if.slave        bus
);
    localparam int ACC_W = 2*DATA_W + $clog2(KERNEL_SIZE) + 1;
    localparam int CW    = ACC_W > OUT_W ? ACC_W : OUT_W;
    localparam int IDX_W = KERNEL_SIZE > 1 ? $clog2(KERNEL_SIZE) : 1;
    localparam int WC_W  = $clog2(RD_LAT + 1);
    localparam logic [IDX_W-1:0]     LAST = IDX_W'(KERNEL_SIZE - 1);
    localparam logic [WC_W-1:0]      WLST = WC_W'(RD_LAT - 1);
    localparam logic signed [CW-1:0] SMAX = CW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [CW-1:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {IDLE, FETCH, READY, MAC, DONE, HOLD} state_t;

    state_t                        state;
    logic [WC_W-1:0]               wcnt;
    logic [IDX_W-1:0]              idx;
    logic signed [ACC_W-1:0]       acc;
    logic [DATA_W*KERNEL_SIZE-1:0] fm_r, k_r;

    logic signed [DATA_W-1:0]   fm_e, k_e;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_nx;
    logic signed [CW-1:0]       ext;
    logic signed [OUT_W-1:0]    sat, fin;

    // Final result uses acc plus the last product so it is ready on DONE entry.
    always_comb begin
        fm_e   = fm_r[idx*DATA_W +: DATA_W];
        k_e    = k_r[idx*DATA_W +: DATA_W];
        prod   = fm_e * k_e;
        acc_nx = acc + ACC_W'(prod);
        ext    = CW'(acc_nx);
        sat    = ext > SMAX ? OUT_W'(SMAX) : ext < SMIN ? OUT_W'(SMIN) : OUT_W'(ext);
`ifdef CONV_RELU_EN
        fin    = sat[OUT_W-1] ? '0 : sat;
`else
        fin    = sat;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state               <= IDLE;
            wcnt                <= '0;
            idx                 <= '0;
            acc                 <= '0;
            fm_r                <= '0;
            k_r                 <= '0;
            bus.o_ready2compute <= 1'b0;
            bus.o_conv_done     <= 1'b0;
            bus.o_result        <= '0;
            bus.o_busy          <= 1'b0;
        end else begin
            bus.o_conv_done <= 1'b0;
            case (state)
                IDLE: if (bus.i_load) begin
                    state      <= FETCH;
                    wcnt       <= '0;
                    bus.o_busy <= 1'b1;
                end
                FETCH: if (!bus.i_load) begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                end else if (wcnt == WLST) begin
                    fm_r                <= bus.i_fm_word;
                    k_r                 <= bus.i_k_word;
                    state               <= READY;
                    bus.o_busy          <= 1'b0;
                    bus.o_ready2compute <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                // Compute wins over a still-asserted load in the same cycle.
                READY: if (bus.i_compute_conv) begin
                    state               <= MAC;
                    acc                 <= '0;
                    idx                 <= '0;
                    bus.o_ready2compute <= 1'b0;
                    bus.o_busy          <= 1'b1;
                end else if (!bus.i_load) begin
                    state               <= IDLE;
                    bus.o_ready2compute <= 1'b0;
                end
                MAC: begin
                    acc <= acc_nx;
                    if (idx == LAST) begin
                        state           <= DONE;
                        bus.o_result    <= fin;
                        bus.o_conv_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state      <= HOLD;
                    bus.o_busy <= 1'b0;
                end
                HOLD: if (!bus.i_compute_conv) begin
                    if (bus.i_load) begin
                        state      <= FETCH;
                        wcnt       <= '0;
                        bus.o_busy <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: directed scoreboard bench for conv_engine
module tb_conv_engine;
    localparam int DW = 8, KS = 3, OW = 16, RL = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_engine_if #(.DATA_W(DW), .KERNEL_SIZE(KS), .OUT_W(OW)) bus ();
    conv_engine #(.DATA_W(DW), .KERNEL_SIZE(KS), .OUT_W(OW), .RD_LAT(RL)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    function automatic int relu(int v);
`ifdef CONV_RELU_EN
        return v < 0 ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [DW*KS-1:0] pk(int a, int b, int c);
        logic [7:0] x, y, z;
        x = a[7:0];
        y = b[7:0];
        z = c[7:0];
        return {z, y, x};
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse is a BRAM2 write checked against the scoreboard.
    always @(negedge clk) begin
        if (bus.o_conv_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 with result %0d expected no done",
                         $signed(bus.o_result));
            end else begin
                chk("bram2_write", int'($signed(bus.o_result)), exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.o_ready2compute !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_row(int f0, int f1, int f2, int k0, int k1, int k2,
                           int e, int hold, bit lat);
        int n;
        bus.i_fm_word = pk(f0, f1, f2);
        bus.i_k_word  = pk(k0, k1, k2);
        bus.i_load    = 1'b1;
        wait_ready(n);
        if (lat) chk("ready_lat", n, RL + 1);
        exp_q.push_back(relu(e));
        bus.i_compute_conv = 1'b1;
        bus.i_load         = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.o_conv_done !== 1'b1 && n < 20);
        if (lat) chk("done_lat", n, KS + 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_result", int'($signed(bus.o_result)), relu(e));
            chk("hold_ready", int'(bus.o_ready2compute), 0);
        end
        bus.i_compute_conv = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int tf[6][3] = '{'{2, 3, 4}, '{-5, 6, -7}, '{10, 20, 30},
                     '{-1, -1, -1}, '{100, -100, 50}, '{127, -128, 127}};
    int tk[6][3] = '{'{1, 1, 1}, '{2, -3, 4}, '{3, 2, 1},
                     '{-1, -1, -1}, '{100, 100, 2}, '{-128, -128, -128}};
    int te[6]    = '{9, -56, 100, 3, 100, -16128};

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int n;
        bus.i_load         = 1'b1;
        bus.i_compute_conv = 1'b0;
        bus.i_fm_word      = '0;
        bus.i_k_word       = '0;
        rst                = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", int'(bus.o_ready2compute), 0);
            chk("rst_done", int'(bus.o_conv_done), 0);
            chk("rst_result", int'(bus.o_result), 0);
            chk("rst_busy", int'(bus.o_busy), 0);
        end
        bus.i_load = 1'b0;
        rst        = 1'b0;
        @(negedge clk);

        run_row(1, 2, 3, 1, 0, -1, -2, 0, 1'b1);
        run_row(127, 127, 127, 127, 127, 127, 32767, 0, 1'b1);
        run_row(-128, -128, -128, 127, 127, 127, -32768, 3, 1'b1);

        bus.i_compute_conv = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(bus.o_busy), 0);
        chk("idle_ready", int'(bus.o_ready2compute), 0);
        bus.i_load = 1'b1;
        @(negedge clk);
        chk("fetch_busy", int'(bus.o_busy), 1);
        bus.i_load = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(bus.o_busy), 0);
        chk("abort_ready", int'(bus.o_ready2compute), 0);
        bus.i_compute_conv = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 6; r++)
            run_row(tf[r][0], tf[r][1], tf[r][2], tk[r][0], tk[r][1], tk[r][2], te[r], 0, 1'b0);

        bus.i_fm_word = pk(50, 60, 70);
        bus.i_k_word  = pk(2, 2, 2);
        bus.i_load    = 1'b1;
        wait_ready(n);
        bus.i_compute_conv = 1'b1;
        bus.i_load         = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmac_busy", int'(bus.o_busy), 0);
        chk("rstmac_result", int'(bus.o_result), 0);
        chk("rstmac_done", int'(bus.o_conv_done), 0);
        rst                = 1'b0;
        bus.i_compute_conv = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstmac_idle_ready", int'(bus.o_ready2compute), 0);

        run_row(1, 2, 3, 4, 5, 6, 32, 0, 1'b1);

        repeat (3) @(negedge clk);
        chk("pending_writes", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
